// File: rtl/riscv_if_pkg.sv
// Shared types and helpers for the instruction-fetch unit.
package riscv_if_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_REQ  = 2'b01,
        IF_WAIT = 2'b10
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/riscv_if_fifo.sv
// Small synchronous FIFO of {inst, pc} entries between fetch and decode.
module riscv_if_fifo
    import riscv_if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  if_entry_t     push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output if_entry_t     head
);
    localparam int AW = $clog2(DEPTH);

    if_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_reg] <= push_data;
    end

    assign count = count_reg;
    // Empty FIFO presents zeros so the decode-facing outputs are clean after reset/flush.
    assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/riscv_if.sv
// Instruction-fetch unit: fetch PC, single-outstanding imem handshake, branch redirect.
module riscv_if
    import riscv_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_i,
    input  logic [31:0] br_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW+1)'(FIFO_DEPTH);

    if_state_e     state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   pend_pc_reg, pend_pc_next;
    logic          discard_reg, discard_next;
    logic          push, pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   count_after;
    logic [31:0]   br_target;
    if_entry_t     push_data;
    if_entry_t     head;

    assign br_target = word_align(br_pc_i);
    assign pop       = inst_valid_o && inst_ready_i;
    assign push      = (state_reg == IF_WAIT) && imem_rvalid_i && !discard_reg && !br_i;
    assign push_data = '{inst: imem_rdata_i, pc: pend_pc_reg};
    // Occupancy after this edge; a branch empties the buffer.
    assign count_after = br_i ? '0 : ({1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop));

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        addr_next     = addr_reg;
        pend_pc_next  = pend_pc_reg;
        discard_next  = discard_reg;
        if (br_i) fetch_pc_next = br_target;
        case (state_reg)
            IF_IDLE: begin
                if (!br_i && (fifo_count < CW'(FIFO_DEPTH))) begin
                    state_next = IF_REQ;
                    addr_next  = fetch_pc_reg;
                end
            end
            IF_REQ: begin
                // The presented request cannot be withdrawn, so its response is marked stale.
                if (br_i) discard_next = 1'b1;
                if (imem_gnt_i) begin
                    state_next   = IF_WAIT;
                    pend_pc_next = addr_reg;
                    if (!br_i && !discard_reg) fetch_pc_next = next_word(fetch_pc_reg);
                end
            end
            IF_WAIT: begin
                if (imem_rvalid_i) begin
                    discard_next = 1'b0;
                    if (count_after < DEPTH_EXT) begin
                        state_next = IF_REQ;
                        addr_next  = fetch_pc_next;
                    end else begin
                        state_next = IF_IDLE;
                    end
                end else if (br_i) begin
                    discard_next = 1'b1;
                end
            end
            default: state_next = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IF_IDLE;
            fetch_pc_reg <= word_align(RESET_PC);
            addr_reg     <= word_align(RESET_PC);
            pend_pc_reg  <= '0;
            discard_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            addr_reg     <= addr_next;
            pend_pc_reg  <= pend_pc_next;
            discard_reg  <= discard_next;
        end
    end

    riscv_if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (br_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (head)
    );

    assign imem_req_o   = (state_reg == IF_REQ);
    assign imem_addr_o  = addr_reg;
    assign inst_valid_o = (fifo_count != '0);
    assign inst_o       = head.inst;
    assign inst_pc_o    = head.pc;

endmodule

// File: tb/tb_riscv_if.sv
// Scoreboard bench for riscv_if: memory model, stream-level expected PC model, directed + random phases.
module tb_riscv_if;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_i = 1'b0;
    logic [31:0] br_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int gnt_pct = 100;
    int lat = 0;
    int gnt_block = 0;
    int cyc = 0;
    int first_req_cyc = -1;
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    int          pop_cyc[$];

    riscv_if #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_i          (br_i),
        .br_pc_i       (br_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Instruction memory: one response at a time, rvalid lat+1 cycles after the grant.
    initial begin : memory_model
        logic        pend;
        logic        hs_prev;
        logic [31:0] hs_addr;
        logic [31:0] paddr;
        int          wait_c;
        pend = 0; hs_prev = 0; hs_addr = '0; paddr = '0; wait_c = 0;
        forever begin
            @(negedge clk); #1;
            if (hs_prev) begin
                pend   = 1'b1;
                paddr  = hs_addr;
                wait_c = (lat < 0) ? int'($urandom_range(2)) : lat;
            end
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            if (pend) begin
                if (wait_c == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_fn(paddr);
                    pend          = 1'b0;
                end else begin
                    wait_c--;
                end
            end
            imem_gnt_i = !pend && (gnt_block == 0) && (int'($urandom_range(99)) < gnt_pct);
            if (gnt_block > 0) gnt_block--;
            hs_prev = imem_req_o && imem_gnt_i;
            hs_addr = imem_addr_o;
        end
    end

    // Monitor: expected stream is sequential words from the last reset/redirect target.
    initial begin : monitor
        logic        prev_br;
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [31:0] e;
        logic [31:0] exp_q[$];
        prev_br = 0; prev_stall = 0; prev_addr = '0;
        exp_q.push_back(RST_PC);
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (!rst_n) begin
                check("rst_req", 32'(imem_req_o), 32'd0);
                check("rst_addr", imem_addr_o, RST_PC);
                check("rst_valid", 32'(inst_valid_o), 32'd0);
                check("rst_inst", inst_o, 32'd0);
                check("rst_pc", inst_pc_o, 32'd0);
                exp_q.delete();
                exp_q.push_back(RST_PC);
                prev_br = 0; prev_stall = 0; first_req_cyc = -1;
            end else begin
                if (prev_br) check("flush_valid", 32'(inst_valid_o), 32'd0);
                if (prev_stall) begin
                    check("req_hold", 32'(imem_req_o), 32'd1);
                    check("addr_hold", imem_addr_o, prev_addr);
                end
                if (imem_req_o && first_req_cyc < 0) first_req_cyc = cyc;
                if (imem_req_o && imem_gnt_i) begin
                    check("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
                    gnt_log.push_back(imem_addr_o);
                end
                if (inst_valid_o && inst_ready_i) begin
                    e = exp_q.pop_front();
                    exp_q.push_back(e + 32'd4);
                    check("inst_pc", inst_pc_o, e);
                    check("inst_data", inst_o, mem_fn(e));
                    pop_log.push_back(inst_pc_o);
                    pop_cyc.push_back(cyc);
                end
                if (br_i) begin
                    exp_q.delete();
                    exp_q.push_back(br_pc_i & 32'hFFFF_FFFC);
                end
                prev_br    = br_i;
                prev_stall = imem_req_o && !imem_gnt_i;
                prev_addr  = imem_addr_o;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        br_i  = 1'b0;
        gnt_log.delete();
        pop_log.delete();
        pop_cyc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (pop_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (pop_log.size() < n) begin
            errors++;
            $display("FAIL timeout_%s: delivered %0d required %0d", name, pop_log.size(), n);
        end
    endtask

    task automatic pulse_branch(input logic [31:0] target);
        br_i    = 1'b1;
        br_pc_i = target;
        @(negedge clk);
        br_i    = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int n0;
        int k;
        int idx;

        // 1: back-to-back fetch, latency and throughput
        gnt_pct = 100; lat = 0; inst_ready_i = 1'b1;
        do_reset();
        wait_pops(3, 40, "t1");
        check("t1_pc0", pop_log[0], 32'h0);
        check("t1_pc1", pop_log[1], 32'h4);
        check("t1_pc2", pop_log[2], 32'h8);
        check("t1_gnt2", gnt_log[2], 32'h8);
        check("t1_latency", 32'(pop_cyc[0] - first_req_cyc), 32'd2);
        check("t1_rate01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
        check("t1_rate12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);

        // 2: decode stalled, buffer fills to depth then fetch stops
        inst_ready_i = 1'b0;
        do_reset();
        repeat (20) @(negedge clk);
        check("t2_valid", 32'(inst_valid_o), 32'd1);
        check("t2_head_pc", inst_pc_o, 32'h0);
        check("t2_req_idle", 32'(imem_req_o), 32'd0);
        check("t2_fetches", 32'(gnt_log.size()), 32'd2);
        inst_ready_i = 1'b1;
        wait_pops(4, 60, "t2");
        check("t2_resume", gnt_log[2], 32'h8);
        check("t2_pc3", pop_log[3], 32'hC);

        // 3: branch while waiting on a slow response
        lat = 2;
        do_reset();
        k = 0;
        while (!(gnt_log.size() >= 2 && !imem_req_o) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("t3_reach_wait", 32'(gnt_log.size() >= 2 && !imem_req_o), 32'd1);
        pulse_branch(32'h100);
        wait_pops(3, 60, "t3");
        check("t3_gnt_target", gnt_log[2], 32'h100);
        check("t3_first_after", pop_log[1], 32'h100);

        // 4: branch while a request is stalled without grant
        lat = 0;
        do_reset();
        gnt_block = 7;
        k = 0;
        while (!imem_req_o && k < 10) begin
            @(negedge clk);
            k++;
        end
        pulse_branch(32'h200);
        @(negedge clk);
        check("t4_req_held", 32'(imem_req_o), 32'd1);
        check("t4_addr_held", imem_addr_o, 32'h0);
        wait_pops(2, 60, "t4");
        check("t4_stale_gnt", gnt_log[0], 32'h0);
        check("t4_gnt_target", gnt_log[1], 32'h200);
        check("t4_first", pop_log[0], 32'h200);

        // 5: unaligned target and PC wrap-around
        do_reset();
        wait_pops(1, 40, "t5a");
        pulse_branch(32'h303);
        n0 = pop_log.size();
        wait_pops(n0 + 1, 40, "t5b");
        check("t5_align", pop_log[n0], 32'h300);
        pulse_branch(32'hFFFF_FFFF);
        n0 = pop_log.size();
        wait_pops(n0 + 2, 40, "t5c");
        check("t5_top", pop_log[n0], 32'hFFFF_FFFC);
        check("t5_wrap", pop_log[n0 + 1], 32'h0);
        idx = -1;
        for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] == 32'hFFFF_FFFC) idx = i;
        check("t5_wrap_fetch", (idx >= 0 && idx + 1 < gnt_log.size()) ? gnt_log[idx + 1] : 32'hDEAD_BEEF, 32'h0);

        // 6: reset pulse mid-wait, late response lands after release
        lat = 3;
        do_reset();
        k = 0;
        while (!(gnt_log.size() >= 2 && !imem_req_o) && k < 40) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        gnt_log.delete(); pop_log.delete(); pop_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_pops(2, 80, "t6");
        check("t6_first_fetch", gnt_log[0], RST_PC);
        check("t6_pc0", pop_log[0], RST_PC);
        check("t6_pc1", pop_log[1], RST_PC + 32'd4);

        // Random phase: random grants, latency, back-pressure and branches
        gnt_pct = 60; lat = -1;
        do_reset();
        repeat (800) begin
            inst_ready_i = ($urandom_range(99) < 70);
            br_i         = ($urandom_range(99) < 5);
            br_pc_i      = $urandom;
            @(negedge clk);
        end
        br_i = 1'b0;
        checks++;
        if (pop_log.size() < 50) begin
            errors++;
            $display("FAIL random_progress: delivered %0d required at least 50", pop_log.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
